// File: rtl/usb_tx_pkg.sv
// Shared types and default timing for the USB TX response scheduler.
package usb_tx_pkg;

  localparam int unsigned PKT_W             = 3;
  localparam int unsigned DEF_TURNAROUND    = 16;
  localparam int unsigned DEF_START_TIMEOUT = 32;
  localparam int unsigned DEF_CNT_W         = 6;

  typedef enum logic [PKT_W-1:0] {
    PKT_IDLE  = 3'd0,
    PKT_DATA  = 3'd1,
    PKT_ACK   = 3'd2,
    PKT_NAK   = 3'd3,
    PKT_STALL = 3'd4
  } tx_pkt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LAUNCH,
    S_WAIT_ACT,
    S_ACTIVE,
    S_DONE,
    S_FAIL
  } sched_state_t;

  typedef struct packed {
    logic    valid;
    tx_pkt_t pkt;
  } pend_slot_t;

  // Software may only request real packet codes.
  function automatic logic req_code_ok(input logic [PKT_W-1:0] code);
    return (code != 3'd0) && (code <= 3'd4);
  endfunction

endpackage

// File: rtl/tx_sched_timer.sv
// Saturating up-counter with clear/enable and a terminal-match flag.
module tx_sched_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             hit_c
);

  always_ff @(posedge clk) begin
    if (!n_rst)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

  assign hit_c = (cnt == term);

endmodule

// File: rtl/tx_response_scheduler.sv
// Chooses the next TX packet from RX events / software requests, enforces the
// bus turnaround gap, launches it to tx_top and tracks completion or failure.
module tx_response_scheduler
  import usb_tx_pkg::*;
#(
  parameter int unsigned TURNAROUND    = DEF_TURNAROUND,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_in_tok,
  input  logic       rx_data_done,
  input  logic       rx_data_err,
  input  logic       rx_buf_full,
  input  logic       ep_halt,
  input  logic       data_ready,
  input  logic [6:0] data_size,
  input  logic [6:0] buff_occ,
  input  logic       sw_req_valid,
  input  logic [2:0] sw_req_pkt,
  input  logic       TX_Transfer_Active,
  input  logic       tx_error,
  output logic [2:0] tx_packet,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       evt_overrun
);

  sched_state_t     state, state_d;
  tx_pkt_t          code, code_d, in_tok_code, data_code, sw_code;
  pend_slot_t       pend, pend_d;
  logic             fail_flag, fail_flag_d;
  logic             overrun_d, sw_ok, rx_ev;
  logic [CNT_W-1:0] cnt, term;
  logic             hit_c, tmr_clr, tmr_en;

  assign tmr_clr = (state_d != state);
  assign tmr_en  = (state == S_GAP) || (state == S_WAIT_ACT);
  assign term    = (state == S_GAP) ? CNT_W'(TURNAROUND - 1) : CNT_W'(START_TIMEOUT - 1);

  tx_sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (term),
    .cnt   (cnt),
    .hit_c (hit_c)
  );

  // Response codes for the two RX event kinds.
  always_comb begin
    in_tok_code = PKT_NAK;
    if (ep_halt)
      in_tok_code = PKT_STALL;
    else if (data_ready && (buff_occ >= data_size) && (data_size != 7'd0))
      in_tok_code = PKT_DATA;
    data_code = PKT_ACK;
    if (ep_halt)          data_code = PKT_STALL;
    else if (rx_buf_full) data_code = PKT_NAK;
  end

  assign sw_ok   = sw_req_valid && req_code_ok(sw_req_pkt);
  assign sw_code = tx_pkt_t'(sw_req_pkt);
  assign rx_ev   = rx_in_tok || rx_data_done;

  always_comb begin
    state_d     = state;
    code_d      = code;
    pend_d      = pend;
    fail_flag_d = fail_flag;
    overrun_d   = 1'b0;

    // Requests that cannot be acted on now go to the pending slot.
    if ((state != S_IDLE) || rx_ev) begin
      if (sw_ok) begin
        if (pend.valid) overrun_d = 1'b1;
        else            pend_d = '{valid: 1'b1, pkt: sw_code};
      end
    end
    if ((state != S_IDLE) && rx_ev) overrun_d = 1'b1;

    case (state)
      S_IDLE: begin
        fail_flag_d = 1'b0;
        if (rx_in_tok) begin
          code_d  = in_tok_code;
          state_d = S_GAP;
          if (rx_data_done) overrun_d = 1'b1;
        end else if (rx_data_done && !rx_data_err) begin
          code_d  = data_code;
          state_d = S_GAP;
        end else if (!rx_ev && pend.valid) begin
          code_d       = pend.pkt;
          state_d      = S_GAP;
          pend_d.valid = sw_ok;
          if (sw_ok) pend_d.pkt = sw_code;
        end else if (!rx_ev && sw_ok) begin
          code_d  = sw_code;
          state_d = S_GAP;
        end
      end
      S_GAP:      if (hit_c) state_d = S_LAUNCH;
      S_LAUNCH:   state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (TX_Transfer_Active) state_d = S_ACTIVE;
        else if (hit_c)         state_d = S_FAIL;
      end
      S_ACTIVE: begin
        if (tx_error) fail_flag_d = 1'b1;
        if (!TX_Transfer_Active)
          state_d = (fail_flag || tx_error) ? S_FAIL : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      code        <= PKT_IDLE;
      pend        <= '{valid: 1'b0, pkt: PKT_IDLE};
      fail_flag   <= 1'b0;
      tx_packet   <= 3'd0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_fail     <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      code        <= code_d;
      pend        <= pend_d;
      fail_flag   <= fail_flag_d;
      tx_packet   <= ((state_d == S_LAUNCH) || (state_d == S_WAIT_ACT)) ? code_d : 3'd0;
      tx_busy     <= (state_d != S_IDLE);
      tx_done     <= (state_d == S_DONE);
      tx_fail     <= (state_d == S_FAIL);
      evt_overrun <= overrun_d;
    end
  end

endmodule

// File: tb/tb_tx_response_scheduler.sv
// Directed bench for tx_response_scheduler with hand-computed expectations.
module tb_tx_response_scheduler;

  logic       tb_clk = 1'b0;
  logic       n_rst, rx_in_tok, rx_data_done, rx_data_err, rx_buf_full, ep_halt;
  logic       data_ready, sw_req_valid, TX_Transfer_Active, tx_error;
  logic [6:0] data_size, buff_occ;
  logic [2:0] sw_req_pkt, tx_packet;
  logic       tx_busy, tx_done, tx_fail, evt_overrun;
  int         checks = 0;
  int         errors = 0;

  always #5 tb_clk = ~tb_clk;

  tx_response_scheduler dut (
    .clk                (tb_clk),
    .n_rst              (n_rst),
    .rx_in_tok          (rx_in_tok),
    .rx_data_done       (rx_data_done),
    .rx_data_err        (rx_data_err),
    .rx_buf_full        (rx_buf_full),
    .ep_halt            (ep_halt),
    .data_ready         (data_ready),
    .data_size          (data_size),
    .buff_occ           (buff_occ),
    .sw_req_valid       (sw_req_valid),
    .sw_req_pkt         (sw_req_pkt),
    .TX_Transfer_Active (TX_Transfer_Active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_fail            (tx_fail),
    .evt_overrun        (evt_overrun)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle RX event; afterwards the bench sits in event cycle + 1.
  task automatic rx_event(input logic in_tok, input logic ddone);
    rx_in_tok = in_tok; rx_data_done = ddone;
    tick();
    rx_in_tok = 1'b0; rx_data_done = 1'b0;
  endtask

  // Checks launch lands exactly at event + 17; pre = cycles already spent past event + 1.
  task automatic expect_launch(input string tag, input logic [2:0] code, input int pre);
    tick(15 - pre);
    chk({tag, "_pre_launch_pkt"}, 32'(tx_packet), 32'd0);
    chk({tag, "_gap_busy"}, 32'(tx_busy), 32'd1);
    tick();
    chk({tag, "_launch_pkt"}, 32'(tx_packet), 32'(code));
  endtask

  // From LAUNCH: run a clean Active pulse and expect tx_done then idle.
  task automatic finish_ok(input string tag);
    tick();
    TX_Transfer_Active = 1'b1;
    tick();
    chk({tag, "_active_pkt"}, 32'(tx_packet), 32'd0);
    TX_Transfer_Active = 1'b0;
    tick();
    chk({tag, "_done"}, 32'(tx_done), 32'd1);
    tick();
    chk({tag, "_done_clear"}, 32'(tx_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; rx_in_tok = 1'b0; rx_data_done = 1'b0; rx_data_err = 1'b0;
    rx_buf_full = 1'b0; ep_halt = 1'b0; data_ready = 1'b0; data_size = 7'd0;
    buff_occ = 7'd0; sw_req_valid = 1'b0; sw_req_pkt = 3'd0;
    TX_Transfer_Active = 1'b0; tx_error = 1'b0;
    tick(2);
    chk("rst_outputs", {27'd0, tx_packet, tx_busy, tx_done, tx_fail, evt_overrun}, 32'd0);
    n_rst = 1'b1;
    tick();

    // DATA response and clean completion
    data_ready = 1'b1; data_size = 7'd8; buff_occ = 7'd8;
    rx_event(1'b1, 1'b0);
    expect_launch("data", 3'd1, 0);
    finish_ok("data");

    // Short FIFO gives NAK, halted endpoint gives STALL
    buff_occ = 7'd3;
    rx_event(1'b1, 1'b0);
    expect_launch("nak", 3'd3, 0);
    finish_ok("nak");
    ep_halt = 1'b1;
    rx_event(1'b1, 1'b0);
    expect_launch("stall", 3'd4, 0);
    finish_ok("stall");
    ep_halt = 1'b0;

    // OUT data: ACK on success, nothing on error
    rx_event(1'b0, 1'b1);
    expect_launch("ack", 3'd2, 0);
    finish_ok("ack");
    rx_data_err = 1'b1;
    rx_event(1'b0, 1'b1);
    rx_data_err = 1'b0;
    chk("err_busy0", 32'(tx_busy), 32'd0);
    tick();
    chk("err_busy1", 32'(tx_busy), 32'd0);

    // Invalid software code is ignored silently
    sw_req_pkt = 3'd5; sw_req_valid = 1'b1;
    tick();
    sw_req_valid = 1'b0;
    chk("badsw_busy", 32'(tx_busy), 32'd0);
    chk("badsw_ovr", 32'(evt_overrun), 32'd0);

    // Start timeout: fail exactly 32 cycles after entering WAIT_ACT
    rx_event(1'b0, 1'b1);
    expect_launch("to", 3'd2, 0);
    tick();
    chk("to_wait_pkt", 32'(tx_packet), 32'd2);
    tick(31);
    chk("to_fail_early", 32'(tx_fail), 32'd0);
    chk("to_busy", 32'(tx_busy), 32'd1);
    tick();
    chk("to_fail", 32'(tx_fail), 32'd1);
    chk("to_fail_pkt", 32'(tx_packet), 32'd0);
    tick();
    chk("to_fail_clear", 32'(tx_fail), 32'd0);
    chk("to_idle_busy", 32'(tx_busy), 32'd0);

    // tx_error mid-transfer turns completion into failure
    rx_event(1'b0, 1'b1);
    expect_launch("err", 3'd2, 0);
    tick();
    TX_Transfer_Active = 1'b1;
    tick(2);
    tx_error = 1'b1;
    tick();
    tx_error = 1'b0;
    tick();
    TX_Transfer_Active = 1'b0;
    tick();
    chk("err_fail", 32'(tx_fail), 32'd1);
    chk("err_nodone", 32'(tx_done), 32'd0);
    tick();

    // Two software ACKs while busy: first queued, second overruns
    rx_event(1'b0, 1'b1);
    sw_req_pkt = 3'd2; sw_req_valid = 1'b1;
    tick();
    chk("q1_ovr", 32'(evt_overrun), 32'd0);
    tick();
    sw_req_valid = 1'b0;
    chk("q2_ovr", 32'(evt_overrun), 32'd1);
    expect_launch("q_first", 3'd2, 2);
    finish_ok("q_first");
    tick();
    expect_launch("q_pend", 3'd2, 0);
    tick();
    TX_Transfer_Active = 1'b1;
    tick(2);
    n_rst = 1'b0;
    tick();
    chk("midrst_outputs", {27'd0, tx_packet, tx_busy, tx_done, tx_fail, evt_overrun}, 32'd0);
    n_rst = 1'b1; TX_Transfer_Active = 1'b0;
    tick();
    chk("postrst_busy", 32'(tx_busy), 32'd0);

    // Simultaneous IN token and OUT done: token wins, overrun flagged
    buff_occ = 7'd8;
    rx_event(1'b1, 1'b1);
    chk("both_ovr", 32'(evt_overrun), 32'd1);
    expect_launch("both", 3'd1, 0);
    finish_ok("both");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
